// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg
//   Shared definitions for the in-order commit controller: default widths,
//   bit offsets of the reorder-entry fields packed into rob_info, and the
//   commit FSM state encoding.
//
//   rob_info layout (LSB first):
//     [0]                         is_su
//     [1]                         is_branch
//     [2 +: rnbit]                rn   (rename copy index)
//     [2+rnbit +: 5]              rd0  (architectural destination)
//     [7+rnbit +: pcw]            pc
package commit_ctrl_pkg;

  localparam int DEF_RNBIT = 2;
  localparam int DEF_PCW   = 64;
  localparam int RD0_W     = 5;
  localparam int INSTRET_W = 64;

  localparam int IS_SU_OFF = 0;
  localparam int IS_BR_OFF = 1;
  localparam int RN_OFF    = 2;

  // Offsets of the fields above rn depend on the rename index width.
  function automatic int rd0_off(input int rnbit);
    return RN_OFF + rnbit;
  endfunction

  function automatic int pc_off(input int rnbit);
    return RN_OFF + rnbit + RD0_W;
  endfunction

  function automatic int info_w(input int rnbit, input int pcw);
    return pcw + RD0_W + rnbit + 2;
  endfunction

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_SU = 2'd1,
    ST_FLUSH   = 2'd2
  } commit_state_e;

endpackage

// File: rtl/commit_ctrl_instret.sv
// instret_cnt
//   Free-running retired-instruction counter. Adds one for every cycle in
//   which inc is high and wraps naturally modulo 2^W.
//
//   Ports:
//     CLK    in   clock, rising edge
//     RSTn   in   asynchronous active-low reset, clears the count
//     inc    in   one retire this cycle
//     count  out  current retired-instruction count
module instret_cnt
  import commit_ctrl_pkg::*;
#(
  parameter int W = INSTRET_W
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl
//   In-order retire controller sitting at the head of an external reorder
//   FIFO. Decides each cycle whether the head entry may retire, pops it,
//   updates the architectural rename table, runs the store-commit handshake
//   with the LSU and raises a one-cycle flush after a mispredicted branch.
//   No reorder entries are stored here.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | normal retire; plain heads pop the cycle they are done
//   ST_WAIT_SU | store head offered to LSU, su_commit held until su_ack
//   ST_FLUSH   | mispredicted branch just retired, flush pulse for 1 cycle
//
//   Ports:
//     CLK, RSTn                  clock / async active-low reset
//     rob_vaild, rob_info        reorder FIFO head entry
//     commit_ready               pop strobe back to the reorder FIFO
//     wbLog                      writeback-done bit per {rd0,rn}
//     archi_vaild/_rd0/_rn       architectural rename-table update
//     bru_res_vaild/_mispredict  branch resolution for the head branch
//     su_commit, su_ack          store-commit handshake with the LSU
//     flush, flush_pc            flush pulse and pc of the flushing branch
//     minstret                   retired-instruction count
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int RNBIT = DEF_RNBIT,
  parameter int PCW   = DEF_PCW
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           rob_vaild,
  input  logic [info_w(RNBIT, PCW)-1:0]  rob_info,
  output logic                           commit_ready,
  input  logic [(32 << RNBIT)-1:0]       wbLog,
  output logic                           archi_vaild,
  output logic [RD0_W-1:0]               archi_rd0,
  output logic [RNBIT-1:0]               archi_rn,
  input  logic                           bru_res_vaild,
  input  logic                           bru_mispredict,
  output logic                           su_commit,
  input  logic                           su_ack,
  output logic                           flush,
  output logic [PCW-1:0]                 flush_pc,
  output logic [INSTRET_W-1:0]           minstret
);

  localparam int IDXW = RD0_W + RNBIT;

  logic [PCW-1:0]   head_pc;
  logic [RD0_W-1:0] head_rd0;
  logic [RNBIT-1:0] head_rn;
  logic             head_br;
  logic             head_su;
  logic [IDXW-1:0]  wb_idx;
  logic             head_done;

  assign head_su  = rob_info[IS_SU_OFF];
  assign head_br  = rob_info[IS_BR_OFF];
  assign head_rn  = rob_info[RN_OFF +: RNBIT];
  assign head_rd0 = rob_info[rd0_off(RNBIT) +: RD0_W];
  assign head_pc  = rob_info[pc_off(RNBIT) +: PCW];

  // x0 never waits on writeback.
  assign wb_idx    = {head_rd0, head_rn};
  assign head_done = (head_rd0 == '0) | wbLog[wb_idx];

  commit_state_e state, state_nxt;
  logic [PCW-1:0] flush_pc_q;
  logic           pop;
  logic           store_req;
  logic           flush_go;

  always_comb begin
    pop       = 1'b0;
    store_req = 1'b0;
    flush_go  = 1'b0;
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (rob_vaild && head_done) begin
          if (head_br) begin
            // Branch heads wait for resolution; a stray bru_res_vaild
            // with any other head type falls through unused.
            if (bru_res_vaild) begin
              pop = 1'b1;
              if (bru_mispredict) begin
                flush_go  = 1'b1;
                state_nxt = ST_FLUSH;
              end
            end
          end else if (head_su) begin
            // Offer the store now; an ack in this same cycle is not taken.
            store_req = 1'b1;
            state_nxt = ST_WAIT_SU;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_WAIT_SU: begin
        store_req = 1'b1;
        // The pop needs the entry still present; an ack that arrives while
        // the head is absent leaves the handshake pending.
        if (su_ack && rob_vaild) begin
          pop       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_RUN;
      flush_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (flush_go) begin
        flush_pc_q <= head_pc;
      end
    end
  end

  // Strobes are qualified by RSTn so they drop the instant reset asserts,
  // even if a retire-able head is sitting at the FIFO output.
  assign commit_ready = pop & RSTn;
  assign archi_vaild  = pop & RSTn;
  assign su_commit    = store_req & RSTn;
  assign archi_rd0    = archi_vaild ? head_rd0 : '0;
  assign archi_rn     = archi_vaild ? head_rn : '0;
  assign flush        = (state == ST_FLUSH);
  assign flush_pc     = flush_pc_q;

  instret_cnt #(
    .W (INSTRET_W)
  ) u_instret_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (commit_ready),
    .count (minstret)
  );

endmodule

// File: tb/tb_commit_ctrl.sv
module tb_commit_ctrl;

  localparam int RNBIT = 2;
  localparam int PCW   = 64;
  localparam int IW    = PCW + 5 + RNBIT + 2;
  localparam int WBW   = 32 << RNBIT;

  logic             CLK;
  logic             RSTn;
  logic             rob_vaild;
  logic [IW-1:0]    rob_info;
  logic             commit_ready;
  logic [WBW-1:0]   wbLog;
  logic             archi_vaild;
  logic [4:0]       archi_rd0;
  logic [RNBIT-1:0] archi_rn;
  logic             bru_res_vaild;
  logic             bru_mispredict;
  logic             su_commit;
  logic             su_ack;
  logic             flush;
  logic [PCW-1:0]   flush_pc;
  logic [63:0]      minstret;

  commit_ctrl #(.RNBIT(RNBIT), .PCW(PCW)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .rob_vaild      (rob_vaild),
    .rob_info       (rob_info),
    .commit_ready   (commit_ready),
    .wbLog          (wbLog),
    .archi_vaild    (archi_vaild),
    .archi_rd0      (archi_rd0),
    .archi_rn       (archi_rn),
    .bru_res_vaild  (bru_res_vaild),
    .bru_mispredict (bru_mispredict),
    .su_commit      (su_commit),
    .su_ack         (su_ack),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .minstret       (minstret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]       rd0;
    logic [RNBIT-1:0] rn;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          assertions = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;

  function automatic logic [IW-1:0] make_info(input logic [PCW-1:0] pc, input logic [4:0] rd0,
                                              input logic [RNBIT-1:0] rn, input logic br, input logic su);
    return {pc, rd0, rn, br, su};
  endfunction

  // Scoreboard: every pop must match the oldest expected retire.
  always @(negedge CLK) begin
    if (commit_ready === 1'b1) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pop: commit_ready=1 at %0t, required no pop", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (archi_vaild !== 1'b1 || archi_rd0 !== mon_e.rd0 || archi_rn !== mon_e.rn) begin
          failures++;
          $display("FAIL sb_archi: got vaild=%b rd0=%0d rn=%0d, required vaild=1 rd0=%0d rn=%0d",
                   archi_vaild, archi_rd0, archi_rn, mon_e.rd0, mon_e.rn);
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] rd0, input logic [RNBIT-1:0] rn);
    exp_t e;
    e.rd0 = rd0;
    e.rn  = rn;
    exp_q.push_back(e);
    exp_instret = exp_instret + 64'd1;
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    rob_vaild = 1'b0; rob_info = '0; wbLog = '0;
    bru_res_vaild = 1'b0; bru_mispredict = 1'b0; su_ack = 1'b0;
    repeat (2) @(negedge CLK);
    // a retire-able plain head during reset must not pop
    rob_info = make_info(64'h10, 5'd0, 2'd0, 1'b0, 1'b0);
    rob_vaild = 1'b1;
    #1;
    assertions++;
    if (commit_ready !== 1'b0 || archi_vaild !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: commit_ready=%b archi_vaild=%b, required 0 0", commit_ready, archi_vaild);
    end
    assertions++;
    if (minstret !== 64'd0) begin
      failures++;
      $display("FAIL reset_minstret: got %0d required 0", minstret);
    end
    assertions++;
    if (flush !== 1'b0 || flush_pc !== '0 || su_commit !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush_su: flush=%b flush_pc=%h su_commit=%b, required 0 0 0", flush, flush_pc, su_commit);
    end
    rob_vaild = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_plain;
    @(posedge CLK); #1;
    wbLog = '0; wbLog[21] = 1'b1;
    rob_info = make_info(64'h100, 5'd5, 2'd1, 1'b0, 1'b0);
    rob_vaild = 1'b1;
    push_exp(5'd5, 2'd1);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1 || archi_vaild !== 1'b1) begin
      failures++;
      $display("FAIL plain_same_cycle: commit_ready=%b archi_vaild=%b, required 1 1", commit_ready, archi_vaild);
    end
    assertions++;
    if (minstret !== 64'd0) begin
      failures++;
      $display("FAIL plain_minstret_before: got %0d required 0", minstret);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
    assertions++;
    if (minstret !== 64'd1) begin
      failures++;
      $display("FAIL plain_minstret_after: got %0d required 1", minstret);
    end
  endtask

  task automatic test_not_done;
    @(posedge CLK); #1;
    wbLog = '0;
    rob_info = make_info(64'h200, 5'd7, 2'd0, 1'b0, 1'b0);
    rob_vaild = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      assertions++;
      if (commit_ready !== 1'b0 || archi_vaild !== 1'b0) begin
        failures++;
        $display("FAIL not_done_wait c=%0d: commit_ready=%b archi_vaild=%b, required 0 0", c, commit_ready, archi_vaild);
      end
      @(posedge CLK); #1;
    end
    wbLog[28] = 1'b1;
    push_exp(5'd7, 2'd0);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL not_done_pop5: commit_ready=%b required 1", commit_ready);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
  endtask

  task automatic test_rd0_zero;
    @(posedge CLK); #1;
    wbLog = '0;
    rob_info = make_info(64'h300, 5'd0, 2'd3, 1'b0, 1'b0);
    rob_vaild = 1'b1;
    push_exp(5'd0, 2'd3);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_zero_pop: commit_ready=%b required 1", commit_ready);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
  endtask

  task automatic test_branch_flush;
    @(posedge CLK); #1;
    wbLog = '0; wbLog[14] = 1'b1;
    rob_info = make_info(64'h0000_0000_8000_0040, 5'd3, 2'd2, 1'b1, 1'b0);
    rob_vaild = 1'b1;
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b0) begin
      failures++;
      $display("FAIL branch_unresolved: commit_ready=%b required 0", commit_ready);
    end
    @(posedge CLK); #1;
    bru_res_vaild = 1'b1; bru_mispredict = 1'b1;
    push_exp(5'd3, 2'd2);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1 || flush !== 1'b0) begin
      failures++;
      $display("FAIL branch_pop: commit_ready=%b flush=%b, required 1 0", commit_ready, flush);
    end
    @(posedge CLK); #1;
    bru_res_vaild = 1'b0; bru_mispredict = 1'b0;
    // a ready plain head must be held off during the flush cycle
    wbLog[33] = 1'b1;
    rob_info = make_info(64'h400, 5'd8, 2'd1, 1'b0, 1'b0);
    @(negedge CLK);
    assertions++;
    if (flush !== 1'b1 || flush_pc !== 64'h0000_0000_8000_0040) begin
      failures++;
      $display("FAIL flush_pulse: flush=%b flush_pc=%h, required 1 0000000080000040", flush, flush_pc);
    end
    assertions++;
    if (commit_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_pop: commit_ready=%b required 0", commit_ready);
    end
    @(posedge CLK); #1;
    push_exp(5'd8, 2'd1);
    @(negedge CLK);
    assertions++;
    if (flush !== 1'b0 || commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_one_cycle: flush=%b commit_ready=%b, required 0 1", flush, commit_ready);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
  endtask

  task automatic test_branch_ok;
    @(posedge CLK); #1;
    wbLog = '0;
    rob_info = make_info(64'h500, 5'd0, 2'd1, 1'b1, 1'b0);
    rob_vaild = 1'b1; bru_res_vaild = 1'b1; bru_mispredict = 1'b0;
    push_exp(5'd0, 2'd1);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL branch_ok_pop: commit_ready=%b required 1", commit_ready);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0; bru_res_vaild = 1'b0;
    @(negedge CLK);
    assertions++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL branch_ok_no_flush: flush=%b required 0", flush);
    end
  endtask

  task automatic test_bru_ignored;
    @(posedge CLK); #1;
    wbLog = '0;
    rob_info = make_info(64'h600, 5'd9, 2'd2, 1'b0, 1'b0);
    rob_vaild = 1'b1; bru_res_vaild = 1'b1; bru_mispredict = 1'b1;
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b0) begin
      failures++;
      $display("FAIL bru_ignored_pop: commit_ready=%b required 0", commit_ready);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
    @(negedge CLK);
    assertions++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL bru_ignored_flush: flush=%b required 0", flush);
    end
    @(posedge CLK); #1;
    bru_res_vaild = 1'b0; bru_mispredict = 1'b0;
  endtask

  task automatic test_store;
    int su_hi;
    su_hi = 0;
    @(posedge CLK); #1;
    wbLog = '0; wbLog[9] = 1'b1;
    rob_info = make_info(64'h700, 5'd2, 2'd1, 1'b0, 1'b1);
    rob_vaild = 1'b1;
    su_ack = 1'b1;  // same cycle as first su_commit: must not count
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        su_ack = 1'b1;
        push_exp(5'd2, 2'd1);
      end
      @(negedge CLK);
      if (su_commit === 1'b1) su_hi++;
      assertions++;
      if (commit_ready !== (c == 3)) begin
        failures++;
        $display("FAIL store_pop c=%0d: commit_ready=%b required %b", c, commit_ready, (c == 3));
      end
      @(posedge CLK); #1;
      su_ack = 1'b0;
      if (c == 3) rob_vaild = 1'b0;
    end
    assertions++;
    if (su_hi != 4) begin
      failures++;
      $display("FAIL store_su_cycles: su_commit high %0d cycles required 4", su_hi);
    end
    assertions++;
    if (minstret !== exp_instret) begin
      failures++;
      $display("FAIL store_minstret: got %0d required %0d", minstret, exp_instret);
    end
  endtask

  task automatic test_reset_wait_su;
    @(posedge CLK); #1;
    wbLog = '0; wbLog[6] = 1'b1;
    rob_info = make_info(64'h800, 5'd1, 2'd2, 1'b0, 1'b1);
    rob_vaild = 1'b1;
    @(posedge CLK); #2;
    assertions++;
    if (su_commit !== 1'b1 || minstret === 64'd0) begin
      failures++;
      $display("FAIL rst_su_pre: su_commit=%b minstret=%0d, required 1 and nonzero", su_commit, minstret);
    end
    RSTn = 1'b0;
    #1;
    exp_instret = 64'd0;
    assertions++;
    if (su_commit !== 1'b0 || commit_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_su_drop: su_commit=%b commit_ready=%b, required 0 0", su_commit, commit_ready);
    end
    assertions++;
    if (minstret !== 64'd0) begin
      failures++;
      $display("FAIL rst_su_minstret: got %0d required 0", minstret);
    end
    rob_vaild = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    wbLog = '0; wbLog[19] = 1'b1;
    rob_info = make_info(64'h900, 5'd4, 2'd3, 1'b0, 1'b0);
    rob_vaild = 1'b1;
    push_exp(5'd4, 2'd3);
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b1 || su_commit !== 1'b0) begin
      failures++;
      $display("FAIL rst_su_run: commit_ready=%b su_commit=%b, required 1 0", commit_ready, su_commit);
    end
    @(posedge CLK); #1;
    rob_vaild = 1'b0;
    assertions++;
    if (minstret !== exp_instret) begin
      failures++;
      $display("FAIL rst_su_count: got %0d required %0d", minstret, exp_instret);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]       rd0;
    logic [RNBIT-1:0] rn;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      rd0 = 5'(i + 10);
      rn  = RNBIT'(i);
      wbLog = '0;
      wbLog[{rd0, rn}] = 1'b1;
      rob_info = make_info(64'(32'hA00 + i * 4), rd0, rn, 1'b0, 1'b0);
      rob_vaild = 1'b1;
      push_exp(rd0, rn);
      @(negedge CLK);
      assertions++;
      if (commit_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_pop i=%0d: commit_ready=%b required 1", i, commit_ready);
      end
      @(posedge CLK); #1;
    end
    // done head but FIFO reports empty
    rob_vaild = 1'b0;
    @(negedge CLK);
    assertions++;
    if (commit_ready !== 1'b0 || archi_vaild !== 1'b0 || archi_rd0 !== 5'd0) begin
      failures++;
      $display("FAIL b2b_empty: commit_ready=%b archi_vaild=%b archi_rd0=%0d, required 0 0 0",
               commit_ready, archi_vaild, archi_rd0);
    end
    @(posedge CLK); #1;
    assertions++;
    if (minstret !== exp_instret) begin
      failures++;
      $display("FAIL b2b_minstret: got %0d required %0d", minstret, exp_instret);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_not_done();
    test_rd0_zero();
    test_branch_flush();
    test_branch_ok();
    test_bru_ignored();
    test_store();
    test_back_to_back();
    test_reset_wait_su();
    repeat (2) @(posedge CLK);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected retires never popped, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 Parameter RNBIT, default 2: rename-copy index width per architectural register.
REQ-002 Parameter PCW, default 64: program-counter width carried in each reorder entry.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 rob_vaild  in  1  reorder FIFO head entry present.
REQ-006 rob_info  in  PCW+5+RNBIT+2  head entry {pc, rd0[4:0], rn[RNBIT-1:0], is_branch, is_su}.
REQ-007 commit_ready  out  1  pop strobe to reorder FIFO.
REQ-008 wbLog  in  32*2^RNBIT  writeback-done bit per {rd0,rn}.
REQ-009 archi_vaild/archi_rd0/archi_rn  out  1/5/RNBIT  architectural rename-table update.
REQ-010 bru_res_vaild, bru_mispredict  in  1,1  branch resolution for head branch.
REQ-011 su_commit  out  1; su_ack  in  1  store-commit handshake to LSU.
REQ-012 flush  out  1  pipeline flush pulse; flush_pc  out  PCW  head pc at flush.
REQ-013 minstret  out  64  retired-instruction count.

Function
REQ-014 States: RUN, WAIT_SU, FLUSH; reset state RUN.
REQ-015 Head "done" = rd0==0 or wbLog[{rd0,rn}]==1.
REQ-016 RUN, plain head (not branch, not su) valid and done: commit_ready=1 and archi_vaild=1 same cycle (combinational, zero added latency), stay RUN.
REQ-017 RUN, branch head: retire only when done and bru_res_vaild=1; mispredict=0 -> retire, stay RUN; mispredict=1 -> retire, go FLUSH.
REQ-018 RUN, store head valid and done: assert su_commit, go WAIT_SU; no pop that cycle.
REQ-019 WAIT_SU: hold su_commit=1 until su_ack=1; that cycle pop (commit_ready=1), archi_vaild=1, return RUN.
REQ-020 su_ack in same cycle as first su_commit is ignored; ack counts only from WAIT_SU.
REQ-021 FLUSH: flush=1 exactly one cycle, flush_pc = registered pc of retired branch, commit_ready=0, then RUN.
REQ-022 rob_vaild=0 or head not done: commit_ready=0, archi_vaild=0, state unchanged.
REQ-023 At most one retire per cycle; commit_ready never asserted when rob_vaild=0.
REQ-024 minstret increments by 1 on every commit_ready pulse; wraps modulo 2^64.
REQ-025 archi_rd0/archi_rn mirror rob_info fields whenever archi_vaild=1; otherwise don't-care driven 0.
REQ-026 bru_res_vaild with no branch at head is ignored.

Reset
REQ-027 RSTn low asynchronously forces RUN, minstret=0, flush_pc=0, all strobes 0.
REQ-028 Reset during WAIT_SU abandons the store handshake; su_commit deasserts immediately.

Structure
REQ-029 Shared package holds RNBIT, PCW, rob_info field offsets and state encoding.
REQ-030 Free-running retire counter is one sub-module: instret_cnt.
REQ-031 No storage of reorder entries; FIFO stays external.

Verification
REQ-032 Plain add rd0=5,rn=1, wbLog bit 21 set -> commit_ready and archi_vaild same cycle, minstret 0->1.
REQ-033 Head rd0=7 with wbLog bit clear 4 cycles, then set -> no pop 4 cycles, pop on 5th.
REQ-034 Branch pc=0x8000_0040, done, bru_res_vaild+mispredict -> pop, next cycle flush=1, flush_pc=0x8000_0040, one cycle only.
REQ-035 Store head, su_ack after 3 cycles -> su_commit high 4 cycles, single pop on ack cycle.
REQ-036 RSTn low in WAIT_SU -> su_commit 0 immediately, minstret 0, RUN after release.
REQ-037 rd0=0 head with wbLog all zero -> commits immediately.
